// File: rtl/instr_fetch.sv
// Instruction fetch unit: issues word-aligned req/gnt/rvalid fetches for the current PC
// and buffers PC-tagged instructions for decode, discarding fetches killed by a redirect.
module instr_fetch #(
  parameter int unsigned DEPTH      = 2,
  parameter logic [31:0] RESET_ADDR = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_pc,
  input  logic        i_pc_valid,
  output logic        o_pc_we,
  output logic        o_instr_req,
  output logic [31:0] o_instr_addr,
  input  logic        i_instr_gnt,
  input  logic        i_instr_rvalid,
  input  logic [31:0] i_instr_rdata,
  input  logic        i_flush,
  output logic        o_id_valid,
  output logic [31:0] o_id_instr,
  output logic [31:0] o_id_pc,
  input  logic        i_id_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, REQ} state_e;

  state_e        state_q, state_d;
  logic          req_q, req_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   req_pc_q, req_pc_d;
  logic          pend_kill_q, pend_kill_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;
  logic [CW-1:0] discard_q, discard_d;
  logic [PW-1:0] oq_wr_q, oq_wr_d, oq_rd_q, oq_rd_d;
  logic [PW-1:0] ff_wr_q, ff_wr_d, ff_rd_q, ff_rd_d;

  logic [31:0] oq_pc    [DEPTH];
  logic [31:0] ff_pc    [DEPTH];
  logic [31:0] ff_instr [DEPTH];

  logic        gnt;
  logic        rsp;
  logic        rsp_keep;
  logic        id_pop;
  logic [CW:0] occ;
  logic        room;

  assign gnt      = req_q & i_instr_gnt;
  assign rsp      = i_instr_rvalid & (out_cnt_q != '0);
  assign rsp_keep = rsp & (discard_q == '0) & ~i_flush;
  assign id_pop   = (fifo_cnt_q != '0) & i_id_ready & ~i_flush;
  assign occ      = {1'b0, fifo_cnt_q} + {1'b0, out_cnt_q};
  assign room     = occ < (CW+1)'(DEPTH);

  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    addr_d      = addr_q;
    req_pc_d    = req_pc_q;
    pend_kill_d = pend_kill_q;
    case (state_q)
      IDLE: begin
        if (i_pc_valid & ~i_flush & room) begin
          state_d  = REQ;
          req_d    = 1'b1;
          addr_d   = {i_pc[31:2], 2'b00};
          req_pc_d = i_pc;
        end
      end
      REQ: begin
        // A request is never retracted; a flush only marks it to be discarded once granted.
        if (i_instr_gnt) begin
          state_d     = IDLE;
          req_d       = 1'b0;
          pend_kill_d = 1'b0;
        end else if (i_flush) begin
          pend_kill_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    out_cnt_d = out_cnt_q + CW'(gnt) - CW'(rsp);
    oq_wr_d   = gnt ? oq_wr_q + PW'(1) : oq_wr_q;
    oq_rd_d   = rsp ? oq_rd_q + PW'(1) : oq_rd_q;

    discard_d = discard_q;
    if (i_flush) begin
      discard_d = out_cnt_d;
    end else begin
      if (rsp && (discard_q != '0)) discard_d = discard_d - CW'(1);
      if (gnt && pend_kill_q)       discard_d = discard_d + CW'(1);
    end

    if (i_flush) begin
      fifo_cnt_d = '0;
      ff_wr_d    = '0;
      ff_rd_d    = '0;
    end else begin
      fifo_cnt_d = fifo_cnt_q + CW'(rsp_keep) - CW'(id_pop);
      ff_wr_d    = rsp_keep ? ff_wr_q + PW'(1) : ff_wr_q;
      ff_rd_d    = id_pop   ? ff_rd_q + PW'(1) : ff_rd_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      req_q       <= 1'b0;
      addr_q      <= RESET_ADDR;
      req_pc_q    <= '0;
      pend_kill_q <= 1'b0;
      out_cnt_q   <= '0;
      fifo_cnt_q  <= '0;
      discard_q   <= '0;
      oq_wr_q     <= '0;
      oq_rd_q     <= '0;
      ff_wr_q     <= '0;
      ff_rd_q     <= '0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      addr_q      <= addr_d;
      req_pc_q    <= req_pc_d;
      pend_kill_q <= pend_kill_d;
      out_cnt_q   <= out_cnt_d;
      fifo_cnt_q  <= fifo_cnt_d;
      discard_q   <= discard_d;
      oq_wr_q     <= oq_wr_d;
      oq_rd_q     <= oq_rd_d;
      ff_wr_q     <= ff_wr_d;
      ff_rd_q     <= ff_rd_d;
    end
  end

  // Storage arrays carry data only; validity is tracked by the counters above.
  always_ff @(posedge i_clk) begin
    if (gnt) oq_pc[oq_wr_q] <= req_pc_q;
    if (rsp_keep) begin
      ff_pc[ff_wr_q]    <= oq_pc[oq_rd_q];
      ff_instr[ff_wr_q] <= i_instr_rdata;
    end
  end

  assign o_pc_we      = gnt;
  assign o_instr_req  = req_q;
  assign o_instr_addr = addr_q;
  assign o_id_valid   = (fifo_cnt_q != '0);
  assign o_id_instr   = o_id_valid ? ff_instr[ff_rd_q] : '0;
  assign o_id_pc      = o_id_valid ? ff_pc[ff_rd_q]    : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch: a memory responder, a transaction-level
// reference model feeding an expected-output queue, and an independent output monitor.
module tb_instr_fetch;
  localparam int          DEPTH = 2;
  localparam logic [31:0] RADDR = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] i_pc;
  logic        i_pc_valid;
  logic        o_pc_we;
  logic        o_instr_req;
  logic [31:0] o_instr_addr;
  logic        i_instr_gnt;
  logic        i_instr_rvalid;
  logic [31:0] i_instr_rdata;
  logic        i_flush;
  logic        o_id_valid;
  logic [31:0] o_id_instr;
  logic [31:0] o_id_pc;
  logic        i_id_ready;

  always #5 clk = ~clk;

  instr_fetch #(.DEPTH(DEPTH), .RESET_ADDR(RADDR)) dut (
    .i_clk(clk), .i_rst(rst), .i_pc(i_pc), .i_pc_valid(i_pc_valid), .o_pc_we(o_pc_we),
    .o_instr_req(o_instr_req), .o_instr_addr(o_instr_addr), .i_instr_gnt(i_instr_gnt),
    .i_instr_rvalid(i_instr_rvalid), .i_instr_rdata(i_instr_rdata), .i_flush(i_flush),
    .o_id_valid(o_id_valid), .o_id_instr(o_id_instr), .o_id_pc(o_id_pc), .i_id_ready(i_id_ready)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mem_word(logic [31:0] a);
    if (a == 32'h80) return 32'h0000_0013;
    return (a ^ 32'h5a5a_0f0f) + (a << 7);
  endfunction

  // Memory side: remembers granted addresses, answers them in order.
  logic [31:0] mem_q[$];
  always @(posedge clk) begin
    if (rst) mem_q.delete();
    else if (o_instr_req && i_instr_gnt) mem_q.push_back(o_instr_addr);
  end

  int dut_gnt = 0;
  always @(posedge clk) if (!rst && o_pc_we) dut_gnt++;

  // Reference model: fetches are records in an in-flight list; a redirect marks them dead.
  typedef struct { logic [31:0] pc; bit dead; } fl_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ex_t;
  fl_t         inflight[$];
  ex_t         exp_q[$];
  int          m_fifo;
  bit          m_req;
  bit          m_kill;
  logic [31:0] m_pc;

  always @(posedge clk) begin : model
    fl_t f;
    int  occ;
    if (rst) begin
      inflight.delete();
      exp_q.delete();
      m_fifo = 0;
      m_req  = 0;
      m_kill = 0;
    end else begin
      occ = m_fifo + inflight.size();
      if (m_fifo > 0 && i_id_ready && !i_flush) m_fifo--;
      if (i_instr_rvalid && inflight.size() > 0) begin
        f = inflight.pop_front();
        if (!f.dead && !i_flush) begin
          exp_q.push_back('{pc: f.pc, instr: mem_word({f.pc[31:2], 2'b00})});
          m_fifo++;
        end
      end
      if (m_req) begin
        if (i_instr_gnt) begin
          inflight.push_back('{pc: m_pc, dead: m_kill});
          m_req  = 0;
          m_kill = 0;
        end else if (i_flush) begin
          m_kill = 1;
        end
      end else if (i_pc_valid && !i_flush && occ < DEPTH) begin
        m_req = 1;
        m_pc  = i_pc;
      end
      if (i_flush) begin
        foreach (inflight[i]) inflight[i].dead = 1;
        exp_q.delete();
        m_fifo = 0;
      end
    end
  end

  // Monitor: compares request-side outputs and pops the scoreboard on each decode transfer.
  always @(negedge clk) begin : monitor
    ex_t e;
    if (!rst) begin
      chk("instr_req", 32'(o_instr_req), 32'(m_req));
      chk("pc_we", 32'(o_pc_we), 32'(m_req && i_instr_gnt));
      chk("id_valid", 32'(o_id_valid), 32'(m_fifo > 0));
      if (m_req) chk("instr_addr", o_instr_addr, {m_pc[31:2], 2'b00});
      if (o_id_valid && i_id_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_id_out", 32'(o_id_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("id_pc", o_id_pc, e.pc);
          chk("id_instr", o_id_instr, e.instr);
        end
      end
    end
  end

  int          p_pcv, p_gnt, p_rv, p_rdy, p_fl;
  bit          fix_pc;
  logic [31:0] pc_val;

  task automatic zero_inputs();
    i_pc = '0; i_pc_valid = 0; i_instr_gnt = 0; i_instr_rvalid = 0;
    i_instr_rdata = '0; i_flush = 0; i_id_ready = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    i_pc        = fix_pc ? pc_val : $urandom;
    i_pc_valid  = int'($urandom_range(99)) < p_pcv;
    i_instr_gnt = o_instr_req && (int'($urandom_range(99)) < p_gnt);
    if (mem_q.size() > 0 && int'($urandom_range(99)) < p_rv) begin
      i_instr_rvalid = 1;
      i_instr_rdata  = mem_word(mem_q.pop_front());
    end else begin
      i_instr_rvalid = 0;
      i_instr_rdata  = $urandom;
    end
    i_flush    = int'($urandom_range(99)) < p_fl;
    i_id_ready = int'($urandom_range(99)) < p_rdy;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    zero_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
  endtask

  int knobs [5][5] = '{'{70, 100, 100, 70, 0},
                       '{80,  40,  50, 60, 5},
                       '{90,  20,  30, 90, 10},
                       '{60,  70,  60, 30, 15},
                       '{100, 50,  80, 50, 3}};
  int g0;

  initial begin
    rst = 1;
    zero_inputs();
    fix_pc = 0; pc_val = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(o_instr_req), 32'd0);
    chk("rst_addr", o_instr_addr, RADDR);
    chk("rst_id_valid", 32'(o_id_valid), 32'd0);
    chk("rst_id_instr", o_id_instr, 32'd0);
    chk("rst_id_pc", o_id_pc, 32'd0);
    chk("rst_pc_we", 32'(o_pc_we), 32'd0);

    // First fetch: memory always ready, response one cycle after grant.
    @(posedge clk);
    #1;
    rst = 0;
    fix_pc = 1; pc_val = 32'h80;
    p_pcv = 100; p_gnt = 100; p_rv = 100; p_rdy = 100; p_fl = 0;
    i_pc = 32'h80; i_pc_valid = 1; i_id_ready = 1;
    step();
    @(negedge clk);
    chk("t1_req_c1", 32'(o_instr_req), 32'd1);
    chk("t1_pcwe_c1", 32'(o_pc_we), 32'd1);
    step();
    step();
    @(negedge clk);
    chk("t1_valid_c3", 32'(o_id_valid), 32'd1);
    chk("t1_pc_c3", o_id_pc, 32'h80);
    chk("t1_instr_c3", o_id_instr, 32'h13);
    fix_pc = 0;

    // Decode stalled: exactly DEPTH grants, then one more after a single pop.
    do_reset();
    p_pcv = 100; p_gnt = 100; p_rv = 100; p_rdy = 0; p_fl = 0;
    g0 = dut_gnt;
    repeat (20) step();
    chk("stall_grants", 32'(dut_gnt - g0), 32'd2);
    @(negedge clk);
    chk("stall_req_low", 32'(o_instr_req), 32'd0);
    p_rdy = 100;
    step();
    p_rdy = 0;
    g0 = dut_gnt;
    repeat (20) step();
    chk("refill_grants", 32'(dut_gnt - g0), 32'd1);

    for (int ph = 0; ph < 5; ph++) begin
      do_reset();
      p_pcv = knobs[ph][0]; p_gnt = knobs[ph][1]; p_rv = knobs[ph][2];
      p_rdy = knobs[ph][3]; p_fl = knobs[ph][4];
      repeat (3000) step();
    end

    p_pcv = 0; p_fl = 0; p_rdy = 100; p_gnt = 100; p_rv = 100;
    repeat (20) step();
    @(negedge clk);
    chk("drain_empty", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
